// File: rtl/exc_ctrl_if.sv
// Pipeline-to-CP0 bundle: M-stage mtc0/mfc0 access, exception inputs and redirect outputs.
interface exc_ctrl_if;
    logic        en;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] M_PC;
    logic        M_BD;
    logic [4:0]  M_ExcCode;
    logic        M_eret;
    logic [5:0]  HWInt;
    logic        Req;
    logic [31:0] EPC;

    modport master (
        output en, addr, wdata, M_PC, M_BD, M_ExcCode, M_eret, HWInt,
        input  rdata, Req, EPC
    );

    modport slave (
        input  en, addr, wdata, M_PC, M_BD, M_ExcCode, M_eret, HWInt,
        output rdata, Req, EPC
    );
endinterface

// File: rtl/exc_ctrl.sv
// CP0 exception/interrupt controller: SR, Cause, EPC, PRId and the M-stage redirect request.
// The handler entry (0x0000_4180) lives in the PC block, not here.
module exc_ctrl #(
    parameter logic [31:0] PRID_VAL = 32'h0011_5151
) (
    input  logic      clk,
    input  logic      reset,
    exc_ctrl_if.slave bus
);

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [31:0] epc_q, epc_d;

    logic int_req, exc_req, req;

    always_comb begin
        int_req = ie_q & ~exl_q & (|(bus.HWInt & im_q));
        exc_req = ~exl_q & (bus.M_ExcCode != 5'd0);
        // Held low during reset so the PC block never redirects while state is clearing.
        req     = reset & (int_req | exc_req);
    end

    always_comb begin
        im_d      = im_q;
        exl_d     = exl_q;
        ie_d      = ie_q;
        bd_d      = bd_q;
        exccode_d = exccode_q;
        epc_d     = epc_q;
        ip_d      = bus.HWInt;

        if (req) begin
            // The M instruction is cancelled, so any mtc0 it carries is dropped.
            exl_d     = 1'b1;
            bd_d      = bus.M_BD;
            exccode_d = int_req ? 5'd0 : bus.M_ExcCode;
            epc_d     = bus.M_BD ? (bus.M_PC - 32'd4) : bus.M_PC;
        end else begin
            if (bus.en) begin
                case (bus.addr)
                    5'd12: begin
                        im_d  = bus.wdata[15:10];
                        exl_d = bus.wdata[1];
                        ie_d  = bus.wdata[0];
                    end
                    5'd14:   epc_d = bus.wdata;
                    default: ;
                endcase
            end
            // eret after the write so it wins on EXL.
            if (bus.M_eret) begin
                exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_q      <= 6'd0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            bd_q      <= 1'b0;
            ip_q      <= 6'd0;
            exccode_q <= 5'd0;
            epc_q     <= 32'd0;
        end else begin
            im_q      <= im_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            bd_q      <= bd_d;
            ip_q      <= ip_d;
            exccode_q <= exccode_d;
            epc_q     <= epc_d;
        end
    end

    always_comb begin
        case (bus.addr)
            5'd12:   bus.rdata = {16'd0, im_q, 8'd0, exl_q, ie_q};
            5'd13:   bus.rdata = {bd_q, 15'd0, ip_q, 3'd0, exccode_q, 2'd0};
            5'd14:   bus.rdata = epc_q;
            5'd15:   bus.rdata = PRID_VAL;
            default: bus.rdata = 32'd0;
        endcase
    end

    assign bus.Req = req;
    assign bus.EPC = epc_q;

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Coprocessor-0 exception/interrupt controller for the five-stage MIPS pipeline. It holds SR, Cause, EPC and PRId, samples exceptions and hardware interrupts at the M stage, and drives the redirect request and the exception return address into the PC register block. It also serves mfc0 reads and mtc0 writes issued from the M stage.

## Interface
- `PRID_VAL`, 32'h0011_5151: constant value returned for PRId (reg 15).
- `HANDLER`, 32'h0000_4180: handler entry address. Documented only; the PC block hard-codes it.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `en` in 1: mtc0 write enable (M stage).
- `addr` in 5: CP0 register number for read and write.
- `wdata` in 32: mtc0 write data.
- `rdata` out 32: mfc0 read data, combinational.
- `M_PC` in 32: PC of the instruction in M (bubbles carry a valid PC).
- `M_BD` in 1: the M instruction is in a branch delay slot.
- `M_ExcCode` in 5: exception code of the M instruction; 0 means none.
- `M_eret` in 1: the M instruction is eret.
- `HWInt` in 6: level-sensitive hardware interrupt lines.
- `Req` out 1: redirect the PC to the handler and flush the pipeline.
- `EPC` out 32: current EPC register value.

## Operation
- SR (12): only bits IM[15:10], EXL[1] and IE[0] are stored. All other bits read 0.
- Cause (13):
  - BD[31], IP[15:10] and ExcCode[6:2] are stored; other bits read 0.
  - Not writable by mtc0; writes to it are ignored.
- EPC (14): full 32 bits, writable by mtc0.
- PRId (15): reads `PRID_VAL`; writes are ignored.
- Any other `addr` reads 0; writes to it are ignored.
- Interrupt condition: `int_req = IE & ~EXL & |(HWInt & IM)`.
- Exception condition: `exc_req = ~EXL & (M_ExcCode != 0)`.
- Request output: `Req = int_req | exc_req`.
  - Combinational.
  - Forced to 0 while `reset` is low.
- On a clock edge with Req=1:
  - EXL <= 1.
  - Cause.BD <= M_BD.
  - Cause.ExcCode <= 0 if int_req, else M_ExcCode. An interrupt outranks a simultaneous exception.
  - EPC <= M_BD ? M_PC-4 : M_PC. Subtraction is 32-bit modulo.
  - mtc0 in that cycle is dropped, because the M instruction is cancelled.
- On a clock edge with M_eret=1 and Req=0: EXL <= 0.
  - Req has priority over eret.
  - Because Req is gated by ~EXL, both occur together only if eret executes with EXL=0. In that case Req wins.
- On a clock edge with en=1, Req=0 and eret inactive:
  - addr 12: IM <= wdata[15:10], EXL <= wdata[1], IE <= wdata[0].
  - addr 14: EPC <= wdata.
- If en=1 and M_eret=1 in the same cycle: the mtc0 write is performed first, then EXL <= 0. The eret clear wins on EXL.
- Cause.IP <= HWInt on every clock edge, regardless of EXL or Req.
- `rdata` reflects register contents before the current edge. There is no write-through bypass.

## Timing
- Reset (reset=0, asynchronous): SR=0, Cause=0, EPC=0. Req=0 and EPC output=0 immediately, without waiting for a clock.
- Reset release: synchronous use begins at the first rising edge after reset goes high.
- Req latency: asserted in the same cycle the condition appears in M (zero cycles). The PC block loads the handler address at that edge.
- State update latency: EXL, Cause and EPC take their new values at the edge where Req=1. Req deasserts in the next cycle because EXL=1.
- EPC output: register value, valid the cycle after the capturing edge. An eret in the following cycle therefore sees the new EPC.
- mtc0 to EPC followed immediately by eret: the new EPC is visible to eret one cycle after the write edge. Hazard stalls are handled by the pipeline control.
- Reset mid-handler (EXL=1): all state clears asynchronously. The PC block restarts at 0x3000.

## Test plan
- Reset with HWInt=6'h3F and M_ExcCode=5'd4: Req=0 throughout. After release, SR, Cause and EPC read 0. PRId reads 32'h0011_5151.
- mtc0 SR=32'h0000_0401, then HWInt[0]=1 with M_PC=32'h3010:
  - Req=1 in that same cycle.
  - Next cycle: EPC=32'h3010, Cause.ExcCode=0, Cause.IP=6'h01, EXL=1, Req=0.
- M_ExcCode=5'd10 with M_BD=1, M_PC=32'h3024, SR=0:
  - Req=1.
  - Then EPC=32'h3020, Cause reads 32'h8000_0028.
- HWInt[2]=1 (IM[2]=1, IE=1) together with M_ExcCode=5'd12: Cause.ExcCode=0, EPC=M_PC.
- With EXL=1: M_ExcCode=5'd4 gives Req=0.
  - eret then clears EXL.
  - The next cycle with a pending interrupt asserts Req.
- en=1, addr=14, wdata=32'h0000_3100 in the same cycle as an M_ExcCode=5'd4 request: the write is dropped and EPC=M_PC.
